sample_checker: RTL and testbench

AXI4-Stream slave that sits at the far end of the `sample_generator` stream and consumes its frames. It applies an optional throttle to `S_AXIS_tready`. Each accepted frame is checked against the generator's incrementing data pattern and against the configured frame length. The block reports per-frame results plus saturating frame and error counters for status readback.

---
 rtl/sample_checker.sv | 80 ++++++++
 tb/tb_sample_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_checker.sv
// sample_checker: AXI4-Stream sink that checks incrementing data and frame length, with saturating status counters.
// Define SAMPLE_CHECKER_THROTTLE_EN to gate ready with a free-running toggle (ready at most every other cycle).
module sample_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 8,
  parameter int C_COUNT_WIDTH = 16
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            En,
  input  logic [7:0]                      FrameSize,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                            S_AXIS_tvalid,
  input  logic                            S_AXIS_tlast,
  output logic                            S_AXIS_tready,
  output logic                            FrameDone,
  output logic                            FrameOk,
  output logic                            DataErr,
  output logic                            LenErr,
  output logic [C_COUNT_WIDTH-1:0]        FrameCount,
  output logic [C_COUNT_WIDTH-1:0]        ErrorCount
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state, state_n;
  logic [8:0] len, cnt, n, lim;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] expct, exp_cur;
  logic err, err_cur, mism, beat, chk, close, lerr, throttle;
`ifdef SAMPLE_CHECKER_THROTTLE_EN
  logic toggle;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) toggle <= 1'b0;
    else toggle <= !toggle;
  assign throttle = toggle;
`else
  assign throttle = 1'b1;
`endif
  assign beat = S_AXIS_tvalid && S_AXIS_tready;
  // In IDLE the current beat is beat 1 of a new frame, so use fresh length/expected values.
  always_comb begin
    lim = state == IDLE ? (FrameSize == 8'd0 ? 9'd256 : {1'b0, FrameSize}) : len;
    n = state == IDLE ? 9'd1 : cnt + 9'd1;
    exp_cur = state == IDLE ? '0 : expct;
    mism = S_AXIS_tdata != exp_cur;
    chk = beat && state != DRAIN;
    close = chk && (S_AXIS_tlast || n == lim);
    lerr = close && (S_AXIS_tlast != (n == lim));
    err_cur = (state == ACTIVE && err) || mism || lerr;
    state_n = state == DRAIN ? (beat && S_AXIS_tlast ? IDLE : DRAIN) :
              !chk ? state : !close ? ACTIVE : S_AXIS_tlast ? IDLE : DRAIN;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      len <= '0;
      cnt <= '0;
      expct <= '0;
      err <= 1'b0;
      S_AXIS_tready <= 1'b0;
      FrameDone <= 1'b0;
      FrameOk <= 1'b0;
      DataErr <= 1'b0;
      LenErr <= 1'b0;
      FrameCount <= '0;
      ErrorCount <= '0;
    end else begin
      state <= state_n;
      S_AXIS_tready <= En && throttle;
      FrameDone <= close;
      FrameOk <= close && !err_cur;
      DataErr <= DataErr || (chk && mism);
      LenErr <= LenErr || lerr;
      if (chk) begin
        len <= lim;
        cnt <= n;
        expct <= exp_cur + C_S_AXIS_TDATA_WIDTH'(1);
        err <= err_cur;
      end
      if (close && !(&FrameCount)) FrameCount <= FrameCount + C_COUNT_WIDTH'(1);
      if (close && err_cur && !(&ErrorCount)) ErrorCount <= ErrorCount + C_COUNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_sample_checker.sv
// tb_sample_checker: randomized frames against a frame-level reference model with a FrameDone scoreboard.
module tb_sample_checker;
  logic Clk = 1'b0, Reset = 1'b1, En = 1'b0;
  logic [7:0] FrameSize = 8'd8, S_AXIS_tdata = 8'd0;
  logic S_AXIS_tvalid = 1'b0, S_AXIS_tlast = 1'b0;
  logic S_AXIS_tready, FrameDone, FrameOk, DataErr, LenErr;
  logic [15:0] FrameCount, ErrorCount;
  int total = 0, bad = 0;
  typedef struct {bit ok; int fc; int ec; bit de; bit le;} exp_t;
  exp_t sb[$];
  logic [7:0] pd[$];
  bit pl[$];
  int m_fc = 0, m_ec = 0;
  bit m_de = 0, m_le = 0;
  bit prev_en = 0, prev_rdy = 0, prev_rst = 1;

  sample_checker dut (
    .Clk(Clk), .Reset(Reset), .En(En), .FrameSize(FrameSize),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tlast(S_AXIS_tlast),
    .S_AXIS_tready(S_AXIS_tready), .FrameDone(FrameDone), .FrameOk(FrameOk),
    .DataErr(DataErr), .LenErr(LenErr), .FrameCount(FrameCount), .ErrorCount(ErrorCount)
  );

  always #5 Clk = !Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && !prev_rst) begin
`ifdef SAMPLE_CHECKER_THROTTLE_EN
      check("rdy_consecutive", {31'd0, S_AXIS_tready && prev_rdy}, 32'd0);
      check("rdy_without_en", {31'd0, S_AXIS_tready && !prev_en}, 32'd0);
`else
      check("rdy_follows_en", {31'd0, S_AXIS_tready}, {31'd0, prev_en});
`endif
    end
    if (!Reset && FrameDone) begin
      if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_ok", {31'd0, FrameOk}, {31'd0, e.ok});
        check("frame_count", {16'd0, FrameCount}, e.fc);
        check("error_count", {16'd0, ErrorCount}, e.ec);
        check("data_err", {31'd0, DataErr}, {31'd0, e.de});
        check("len_err", {31'd0, LenErr}, {31'd0, e.le});
      end
    end
    prev_en = En;
    prev_rdy = S_AXIS_tready;
    prev_rst = Reset;
  end

  task automatic send(input logic [7:0] d, input bit l);
    bit acc;
    int k = 0;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata = d;
    S_AXIS_tlast = l;
    do begin
      @(negedge Clk);
      acc = S_AXIS_tready;
      @(posedge Clk);
      #1;
      k++;
    end while (!acc && k < 200);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic en_drop();
    S_AXIS_tvalid = 1'b0;
    En = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("rdy_off_after_en", {31'd0, S_AXIS_tready}, 32'd0);
    repeat (9) @(posedge Clk);
    #1 En = 1'b1;
  endtask

  task automatic make_pkt(input int kind, input logic [7:0] sz);
    int len, n, idx;
    len = sz == 8'd0 ? 256 : int'(sz);
    if (kind == 2 && len == 1) kind = 0;
    n = kind == 2 ? int'($urandom_range(1, len - 1)) : kind == 3 ? len + int'($urandom_range(1, 3)) : len;
    pd.delete();
    pl.delete();
    for (int i = 0; i < n; i++) begin
      pd.push_back(8'(i));
      pl.push_back(i == n - 1);
    end
    if (kind == 1) begin
      idx = $urandom_range(0, n - 1);
      pd[idx] = pd[idx] ^ 8'($urandom_range(1, 255));
    end
  endtask

  // Frame-level model: the frame closes at the first beat carrying tlast or reaching the length.
  task automatic run_pkt(input logic [7:0] sz, input int drop_at, input bit gaps);
    int len, ci;
    bit dbad, lbad;
    exp_t e;
    len = sz == 8'd0 ? 256 : int'(sz);
    ci = 0;
    while (!(pl[ci] || ci + 1 == len)) ci++;
    dbad = 0;
    for (int j = 0; j <= ci; j++) if (pd[j] != 8'(j)) dbad = 1;
    lbad = !(pl[ci] && ci + 1 == len);
    m_fc = m_fc == 65535 ? m_fc : m_fc + 1;
    if (dbad || lbad) m_ec = m_ec == 65535 ? m_ec : m_ec + 1;
    m_de |= dbad;
    m_le |= lbad;
    e = '{ok: !(dbad || lbad), fc: m_fc, ec: m_ec, de: m_de, le: m_le};
    sb.push_back(e);
    FrameSize = sz;
    for (int i = 0; i < pd.size(); i++) begin
      if (i == drop_at) en_drop();
      send(pd[i], pl[i]);
      if (i == 0) FrameSize = 8'($urandom);
      if (gaps && $urandom_range(0, 3) == 0) begin
        S_AXIS_tvalid = 1'b0;
        @(posedge Clk);
        #1;
      end
    end
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_ready", {31'd0, S_AXIS_tready}, 32'd0);
    check("rst_done", {31'd0, FrameDone}, 32'd0);
    check("rst_count", {16'd0, FrameCount}, 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    En = 1'b1;
    repeat (3) begin
      make_pkt(0, 8'd8);
      run_pkt(8'd8, -1, 0);
    end
    make_pkt(0, 8'd4);
    pd[2] = 8'd5;
    run_pkt(8'd4, -1, 0);
    make_pkt(0, 8'd4);
    run_pkt(8'd4, -1, 0);
    make_pkt(0, 8'd5);
    pl[4] = 1'b1;
    run_pkt(8'd8, -1, 0);
    make_pkt(0, 8'd8);
    run_pkt(8'd8, -1, 0);
    make_pkt(0, 8'd6);
    run_pkt(8'd4, -1, 0);
    make_pkt(0, 8'd0);
    run_pkt(8'd0, -1, 0);
    make_pkt(0, 8'd2);
    run_pkt(8'd2, -1, 0);
    for (int t = 0; t < 30; t++) begin
      logic [7:0] sz;
      sz = 8'($urandom_range(1, 12));
      make_pkt($urandom_range(0, 3), sz);
      run_pkt(sz, -1, 1);
    end
    make_pkt(0, 8'd8);
    run_pkt(8'd8, 4, 0);
    FrameSize = 8'd8;
    for (int i = 0; i < 3; i++) send(8'(i), 1'b0);
    S_AXIS_tvalid = 1'b0;
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, S_AXIS_tready}, 32'd0);
    check("mid_rst_done", {31'd0, FrameDone}, 32'd0);
    check("mid_rst_ok", {31'd0, FrameOk}, 32'd0);
    check("mid_rst_data_err", {31'd0, DataErr}, 32'd0);
    check("mid_rst_len_err", {31'd0, LenErr}, 32'd0);
    check("mid_rst_fcount", {16'd0, FrameCount}, 32'd0);
    check("mid_rst_ecount", {16'd0, ErrorCount}, 32'd0);
    check("pending_at_rst", sb.size(), 32'd0);
    m_fc = 0;
    m_ec = 0;
    m_de = 0;
    m_le = 0;
    repeat (2) @(posedge Clk);
    #3 Reset = 1'b0;
    @(posedge Clk);
    #1;
    make_pkt(0, 8'd4);
    run_pkt(8'd4, -1, 0);
    make_pkt(1, 8'd6);
    run_pkt(8'd6, -1, 1);
    repeat (5) @(posedge Clk);
    check("pending_at_end", sb.size(), 32'd0);
    check("final_fcount", {16'd0, FrameCount}, m_fc);
    check("final_ecount", {16'd0, ErrorCount}, m_ec);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
